serial_subtractor: RTL

//  Bit-serial unsigned subtractor: computes d = a - b (mod 2^bit_width) and the borrow-out, one bit
//  per clock, LSB first, through a single full-subtractor cell and a borrow flop.
//  It is the inverse-operation, area-minimal companion to the parallel ripple adder, for datapaths

---
 rtl/serial_subtractor.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, one full-subtractor cell per clock, LSB first.
// Latency bit_width cycles from accept; result held in DONE until out_ready, no new accept meanwhile.
module serial_subtractor #(
    parameter int bit_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bit_width-1:0] a,
    input  logic [bit_width-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bit_width-1:0] d,
    output logic                 bout
);
    localparam int            CW   = (bit_width > 1) ? $clog2(bit_width) : 1;
    localparam logic [CW-1:0] LAST = CW'(bit_width - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [bit_width-1:0] a_sr_q;
    logic [bit_width-1:0] b_sr_q;
    logic [bit_width-1:0] res_q;
    logic [bit_width-1:0] d_q;
    logic [CW-1:0]        count_q;
    logic                 borrow_q;
    logic                 bout_q;
    logic                 out_valid_q;

    logic                 ai;
    logic                 bi;
    logic                 di;
    logic                 borrow_d;
    logic [bit_width-1:0] res_d;

    always_comb begin
        ai       = a_sr_q[0];
        bi       = b_sr_q[0];
        di       = ai ^ bi ^ borrow_q;
        borrow_d = (~ai & bi) | (~(ai ^ bi) & borrow_q);
        res_d    = res_q >> 1;
        res_d[bit_width-1] = di;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            res_q       <= '0;
            d_q         <= '0;
            count_q     <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    // The final bit's difference and borrow go straight into the output registers.
                    if (count_q == LAST) begin
                        d_q         <= res_d;
                        bout_q      <= borrow_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;
endmodule
